operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 186 ++++++++++++++++++
 tb/tb_operand_fetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts a decoded instruction, reads both source
// operands from a registered-read regfile, bypasses a same-cycle writeback,
// and hands the operands to execute with a valid/ready handshake.
// A per-register busy scoreboard stalls an instruction whose sources are
// still waiting on an in-flight writer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          decoded instruction handshake
//   in_rs1, in_rs2, in_rd      source / destination register indices
//   in_rd_wen                  instruction writes in_rd
//   rf_raddr1/2, rf_rdata1/2   regfile read port (data arrives one cycle later)
//   wb_valid/wb_addr/wb_data   writeback (same signals as the regfile write port)
//   out_valid/out_ready        operand handoff to execute
//   out_op1/2, out_rd, out_rd_wen  operands and destination for execute
//   flush                      squash the in-flight instruction, clear scoreboard

package core_cfg;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned XLEN           = 64;
endpackage

module operand_fetch #(
  parameter int unsigned ADDR_WIDTH = core_cfg::REG_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = core_cfg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_wen,
  input  logic                  flush
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic                  rd_wen_q;
  logic                  byp1_q, byp2_q;
  logic [DATA_WIDTH-1:0] byp1_data_q, byp2_data_q;
  logic [DATA_WIDTH-1:0] hold1_q, hold2_q;

  logic                  haz1, haz2;
  logic                  wb_hit1, wb_hit2;
  logic                  handoff;
  logic                  accept;
  logic [DATA_WIDTH-1:0] fetch_op1, fetch_op2;

  // Writeback matching an incoming source; x0 never matches.
  assign wb_hit1 = wb_valid && (wb_addr == in_rs1) && (wb_addr != '0);
  assign wb_hit2 = wb_valid && (wb_addr == in_rs2) && (wb_addr != '0);

  // A busy source is released by a writeback to it in the same cycle.
  assign haz1 = (in_rs1 != '0) && busy_q[in_rs1] && !wb_hit1;
  assign haz2 = (in_rs2 != '0) && busy_q[in_rs2] && !wb_hit2;

  // Regfile returns pre-write data, so a writeback seen at accept wins.
  assign fetch_op1 = byp1_q ? byp1_data_q : rf_rdata1;
  assign fetch_op2 = byp2_q ? byp2_data_q : rf_rdata2;

  assign out_rd     = rd_q;
  assign out_rd_wen = rd_wen_q;

  // Next state and handshake/output decode.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_op1   = '0;
    out_op2   = '0;
    handoff   = 1'b0;
    in_ready  = 1'b0;
    accept    = 1'b0;
    rf_raddr1 = rs1_q;
    rf_raddr2 = rs2_q;

    case (state_q)
      FETCH: begin
        out_valid = 1'b1;
        out_op1   = fetch_op1;
        out_op2   = fetch_op2;
      end
      HOLD: begin
        out_valid = 1'b1;
        out_op1   = hold1_q;
        out_op2   = hold2_q;
      end
      default: ;
    endcase

    handoff  = out_valid && out_ready;
    in_ready = rst_n && !flush && !haz1 && !haz2 && ((state_q == IDLE) || handoff);
    accept   = in_valid && in_ready;

    if (accept) begin
      rf_raddr1 = in_rs1;
      rf_raddr2 = in_rs2;
    end

    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = handoff ? (accept ? FETCH : IDLE) : HOLD;
      HOLD:    if (handoff) state_d = accept ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  // Scoreboard update: clear on writeback, set on accept (set wins).
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (accept && in_rd_wen && (in_rd != '0)) busy_d[in_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Instruction latch, bypass capture and operand hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
      hold1_q     <= '0;
      hold2_q     <= '0;
    end else begin
      if (accept) begin
        rs1_q       <= in_rs1;
        rs2_q       <= in_rs2;
        rd_q        <= in_rd;
        rd_wen_q    <= in_rd_wen;
        byp1_q      <= wb_hit1;
        byp2_q      <= wb_hit2;
        byp1_data_q <= wb_data;
        byp2_data_q <= wb_data;
      end
      // Freeze operands when execute stalls; regfile output may change later.
      if ((state_q == FETCH) && !out_ready && !flush) begin
        hold1_q <= fetch_op1;
        hold2_q <= fetch_op2;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: registered-read regfile fixture, an operand-level
// reference model compared every negedge, and directed scenarios with
// hand-computed literal expectations.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_wen;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [63:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic        flush;

  int vectors = 0;
  int miscompares = 0;
  int dut_hs = 0;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile fixture: registered read returning pre-write data.
  logic [63:0] rf [32];

  function automatic logic [63:0] init_val(input int i);
    case (i)
      0:       return 64'h0;
      3:       return 64'h11;
      4:       return 64'h22;
      default: return 64'(i) * 64'h101;
    endcase
  endfunction

  always @(posedge clk) begin
    rf_rdata1 <= rf[rf_raddr1];
    rf_rdata2 <= rf[rf_raddr2];
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (wb_valid && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one pending instruction carrying its architectural operand values.
  bit          m_pend;
  logic [63:0] m_op1, m_op2;
  logic [4:0]  m_rd;
  logic        m_wen;
  bit          m_busy [32];
  bit          m_acc;
  int          m_hs = 0;

  function automatic bit m_stalled(input logic [4:0] rs);
    return (rs != 5'd0) && m_busy[rs] && !(wb_valid && wb_addr == rs);
  endfunction

  function automatic bit m_ready();
    if (!rst_n || flush) return 1'b0;
    if (m_pend && !out_ready) return 1'b0;
    if (m_stalled(in_rs1) || m_stalled(in_rs2)) return 1'b0;
    return 1'b1;
  endfunction

  // Current architectural value of a register, including a writeback this cycle.
  function automatic logic [63:0] m_value(input logic [4:0] rs);
    if (rs == 5'd0) return 64'h0;
    if (wb_valid && wb_addr == rs) return wb_data;
    return rf[rs];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 1'b0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      m_acc = in_valid && m_ready();
      if (m_pend && out_ready) m_hs++;
      if (flush) begin
        m_pend = 1'b0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (m_pend && out_ready) m_pend = 1'b0;
        if (m_acc) begin
          m_op1  = m_value(in_rs1);
          m_op2  = m_value(in_rs2);
          m_rd   = in_rd;
          m_wen  = in_rd_wen;
          m_pend = 1'b1;
        end
        if (wb_valid && wb_addr != 5'd0) m_busy[wb_addr] = 1'b0;
        if (m_acc && in_rd_wen && in_rd != 5'd0) m_busy[in_rd] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) dut_hs++;
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    chk("model in_ready", 64'(in_ready), 64'(m_ready()));
    chk("model out_valid", 64'(out_valid), 64'(m_pend));
    if (m_pend) begin
      chk("model out_op1", out_op1, m_op1);
      chk("model out_op2", out_op2, m_op2);
      chk("model out_rd", 64'(out_rd), 64'(m_rd));
      chk("model out_rd_wen", 64'(out_rd_wen), 64'(m_wen));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen);
    in_valid  = 1'b1;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    in_rd_wen = wen;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_rd_wen = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset state, with an instruction already offered.
    offer(5'd3, 5'd4, 5'd0, 1'b0);
    step(); step();
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_op1", out_op1, 64'd0);
    chk("reset out_op2", out_op2, 64'd0);
    chk("reset out_rd", 64'(out_rd), 64'd0);
    chk("reset out_rd_wen", 64'(out_rd_wen), 64'd0);

    // Basic fetch and back-to-back throughput.
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("first accept ready", 64'(in_ready), 64'd1);
    step();
    chk("b2b out_valid", 64'(out_valid), 64'd1);
    chk("b2b op1 x3", out_op1, 64'h11);
    chk("b2b op2 x4", out_op2, 64'h22);
    offer(5'd1, 5'd2, 5'd0, 1'b0);
    step();
    chk("b2b op1 x1", out_op1, 64'h101);
    chk("b2b op2 x2", out_op2, 64'h202);
    offer(5'd5, 5'd6, 5'd0, 1'b0);
    step();
    chk("b2b op1 x5", out_op1, 64'h505);
    chk("b2b op2 x6", out_op2, 64'h606);
    in_valid = 1'b0;
    step();
    chk("b2b drain", 64'(out_valid), 64'd0);

    // RAW hazard released by writeback, with bypass.
    offer(5'd1, 5'd2, 5'd5, 1'b1);
    step();
    offer(5'd5, 5'd0, 5'd0, 1'b0);
    #1 chk("raw stall 0", 64'(in_ready), 64'd0);
    step();
    chk("raw stall 1", 64'(in_ready), 64'd0);
    step();
    chk("raw stall 2", 64'(in_ready), 64'd0);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 64'hAB;
    #1 chk("raw release", 64'(in_ready), 64'd1);
    step();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("raw bypass op1", out_op1, 64'hAB);
    chk("raw op2 x0", out_op2, 64'd0);
    step();

    // Execute stall with unrelated regfile writes.
    out_ready = 1'b0;
    offer(5'd3, 5'd4, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("stall fetch valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 64'h900 + 64'(i);
      step();
      chk("stall hold valid", 64'(out_valid), 64'd1);
      chk("stall hold op1", out_op1, 64'h11);
      chk("stall hold op2", out_op2, 64'h22);
    end
    wb_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("stall release", 64'(out_valid), 64'd0);

    // Writeback to x0 neither bypasses nor stalls.
    offer(5'd0, 5'd3, 5'd0, 1'b0);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 64'hFF;
    #1 chk("x0 no stall", 64'(in_ready), 64'd1);
    step();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("x0 op1", out_op1, 64'd0);
    chk("x0 op2", out_op2, 64'h11);
    step();

    // Flush in HOLD clears the scoreboard.
    out_ready = 1'b0;
    offer(5'd1, 5'd2, 5'd7, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    offer(5'd7, 5'd0, 5'd0, 1'b0);
    #1 chk("flush pre busy", 64'(in_ready), 64'd0);
    flush = 1'b1;
    #1 chk("flush no accept", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    #1 chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush x7 ready", 64'(in_ready), 64'd1);
    step();
    chk("flush accept valid", 64'(out_valid), 64'd1);
    chk("flush accept op1", out_op1, 64'h707);
    in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Asynchronous reset mid-FETCH.
    out_ready = 1'b0;
    offer(5'd3, 5'd4, 5'd6, 1'b0);
    step();
    in_valid = 1'b0;
    chk("areset pre valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("areset out_valid", 64'(out_valid), 64'd0);
    chk("areset out_op1", out_op1, 64'd0);
    chk("areset out_op2", out_op2, 64'd0);
    chk("areset out_rd", 64'(out_rd), 64'd0);
    chk("areset in_ready", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("areset dropped", 64'(out_valid), 64'd0);
    step();

    chk("model handshakes", 64'(m_hs), 64'd8);
    chk("dut handshakes", 64'(dut_hs), 64'(m_hs));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
